alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Execute-stage ALU, directly downstream of the ALU control decoder. Consumes its 4-bit alu_control code plus operands.
- Computes AND/OR/ADD/SUB/SLT in one cycle. Computes SLL with a serial 1-bit-per-cycle shifter, trading latency for area.
- start/busy/done handshake lets the CPU controller stall the PC while a shift is in flight.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- alu_control  in  4  op code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1111 SLL.
- a  in  WIDTH  operand A (rs).
- b  in  WIDTH  operand B (rt or sign-extended immediate); SLL source.
- shamt  in  SHAMT_W  shift amount for SLL.
- result  out  WIDTH  registered result, held until the next completion.
- zero  out  1  registered (result == 0).
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0): state IDLE, result=0, zero=1, busy=0, done=0, shift counter=0, shift register=0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE & start & op!=1111: result/zero registered at the sampling edge E; go to DONE.
  - IDLE & start & op==1111 & shamt==0: result=b; go to DONE.
  - IDLE & start & op==1111 & shamt>0: shift reg=b, cnt=shamt; go to SHIFT.
  - SHIFT: each edge does reg<<=1 (zero fill) and cnt-=1. On the edge where cnt goes 1->0, result=shifted value, zero updated, go to DONE.
  - DONE: done=1 for exactly this cycle; next edge returns to IDLE unconditionally.
- Latency: define cycle E+1 as the cycle after the sampling edge.
  - Non-shift ops: done in cycle E+1.
  - SLL: done in cycle E+1+shamt.
- Throughput: a new start is accepted at best every 2 cycles. start is ignored in SHIFT and DONE (not queued).
- Inputs a, b, alu_control and shamt are sampled only at edge E; later changes have no effect on the in-flight op.
- Arithmetic:
  - ADD/SUB are modulo 2^WIDTH.
  - SLT is signed: result = {WIDTH-1 zeros, (a-b) sign corrected for overflow}.
  - AND/OR are bitwise.
- Unlisted alu_control codes: result=0, zero=1, done in E+1.
- Reset asserted mid-SHIFT aborts immediately; all outputs take reset values and no done is issued.
- result and zero change only on completion edges or reset.

Optional Feature:
- Macro ALU_OVF_EN.
- Defined:
  - Adds output port overflow (out, 1).
  - Registered with result: 1 when ADD/SUB signed overflow occurs, i.e. operand signs match (ADD) or differ (SUB) and the result sign differs from a.
  - 0 for all other ops; reset value 0.
- Undefined: no overflow port and no overflow logic.

Decomposition:
- Package alu_pkg:
  - localparams for the six op codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLL).
  - FSM state encoding (2-bit).
- Sub-module alu_seq_shifter: serial left shifter holding reg/cnt, with load, busy and last outputs. The FSM and single-cycle datapath stay in alu_seq.

Test Plan:
- ADD: reset, then start with op=0010, a=5, b=7 -> done in E+1, result=12, zero=0, busy high only in E+1.
- SUB and zero: op=0110, a=3, b=3 -> result=0, zero=1. Then op=0111, a=0xFFFFFFFF, b=1 -> result=1 (signed -1<1).
- SLL latency: op=1111, b=0x1, shamt=4 -> busy for 5 cycles, done in E+5, result=0x10. With shamt=0 and b=0xABCD -> done in E+1, result=0xABCD.
- start during SHIFT: op=1111, b=0x3, shamt=31, plus extra start pulses with op=0010 during SHIFT -> extras ignored, single done in E+32, result=0x80000000.
- Reset mid-shift: shamt=10, rst_n low at E+3 -> result=0, zero=1, busy=0, no done. A subsequent ADD 1+1 gives result=2.
- ALU_OVF_EN: ADD a=0x7FFFFFFF, b=1 -> result=0x80000000, overflow=1. SUB a=0x80000000, b=1 -> overflow=1. AND -> overflow=0.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Purpose : Shared definitions for the sequential execute-stage ALU: the
//           4-bit alu_control op codes and the 2-bit FSM state encoding.
// Ports   : none (package)
// Config  : none here; the optional overflow flag is enabled by ALU_OVF_EN
//           in alu_seq.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    // Op codes as produced by the upstream ALU control decoder
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_seq_shifter.sv
// ============================================================================
// Module  : alu_seq_shifter
// Purpose : Serial left shifter, one bit position per clock, zero fill.
//           A load captures the source word and the shift count; the word
//           is then shifted once per edge until the count reaches zero.
// Ports   : clk       - clock, rising edge
//           rst_n     - asynchronous active-low reset
//           load_i    - capture data_i / shamt_i this edge
//           data_i    - word to shift
//           shamt_i   - number of positions to shift
//           shifted_o - current register shifted by one (value after next edge)
//           busy_o    - shifts still outstanding
//           last_o    - the coming edge performs the final shift
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic [WIDTH-1:0]   shifted_o,
    output logic               busy_o,
    output logic               last_o
);

    logic [WIDTH-1:0]   sreg_q;
    logic [SHAMT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else if (load_i) begin
            sreg_q <= data_i;
            cnt_q  <= shamt_i;
        end else if (cnt_q != '0) begin
            sreg_q <= shifted_o;
            cnt_q  <= cnt_q - SHAMT_W'(1);
        end
    end

    // Exposing the pre-shifted value lets the owner capture the final
    // result on the same edge that the count goes 1 -> 0.
    assign shifted_o = sreg_q << 1;
    assign busy_o    = (cnt_q != '0);
    assign last_o    = (cnt_q == SHAMT_W'(1));

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module  : alu_seq
// Purpose : Execute-stage ALU. AND/OR/ADD/SUB/SLT complete in one cycle;
//           SLL uses a serial shifter (one bit per cycle). A start/busy/done
//           handshake lets the controller stall while a shift is in flight.
// Ports   : clk, rst_n (async active-low), start, alu_control[3:0],
//           a, b [WIDTH], shamt [SHAMT_W]  -> result [WIDTH], zero, busy,
//           done, and overflow when ALU_OVF_EN is defined.
// Config  : `define ALU_OVF_EN adds the registered signed-overflow flag
//           for ADD/SUB.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         alu_control,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               busy,
    output logic               done
`ifdef ALU_OVF_EN
    ,
    output logic               overflow
`endif
);

    alu_state_t       state_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             done_q;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             ovf_sub;
    logic             slt;
    logic [WIDTH-1:0] result_d;

    logic             sh_load;
    logic [WIDTH-1:0] sh_shifted;
    logic             sh_last;

`ifdef ALU_OVF_EN
    logic ovf_add;
    logic ovf_d;
    logic ovf_q;
`endif

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    always_comb begin
        sum      = a + b;
        diff     = a - b;
        ovf_sub  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        // Signed less-than: the sign of a-b is wrong exactly when it overflowed
        slt      = diff[WIDTH-1] ^ ovf_sub;
        result_d = '0;
        unique case (alu_control)
            ALU_AND: result_d = a & b;
            ALU_OR:  result_d = a | b;
            ALU_ADD: result_d = sum;
            ALU_SUB: result_d = diff;
            ALU_SLT: result_d = {{(WIDTH-1){1'b0}}, slt};
            ALU_SLL: result_d = b;   // only used directly when shamt == 0
            default: result_d = '0;
        endcase
    end

`ifdef ALU_OVF_EN
    always_comb begin
        ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        ovf_d   = 1'b0;
        if (alu_control == ALU_ADD) begin
            ovf_d = ovf_add;
        end else if (alu_control == ALU_SUB) begin
            ovf_d = ovf_sub;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Serial shifter: loaded only for a real (non-zero) shift
    // ------------------------------------------------------------------
    assign sh_load = (state_q == ST_IDLE) && start &&
                     (alu_control == ALU_SLL) && (shamt != '0);

    alu_seq_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (sh_load),
        .data_i    (b),
        .shamt_i   (shamt),
        .shifted_o (sh_shifted),
        .busy_o    (),
        .last_o    (sh_last)
    );

    // ------------------------------------------------------------------
    // Control FSM with registered result/zero/done
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
`ifdef ALU_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (sh_load) begin
                            state_q <= ST_SHIFT;
                        end else begin
                            result_q <= result_d;
                            zero_q   <= (result_d == '0);
`ifdef ALU_OVF_EN
                            ovf_q    <= ovf_d;
`endif
                            done_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (sh_last) begin
                        result_q <= sh_shifted;
                        zero_q   <= (sh_shifted == '0);
`ifdef ALU_OVF_EN
                        ovf_q    <= 1'b0;
`endif
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign done   = done_q;
    assign busy   = (state_q != ST_IDLE);
`ifdef ALU_OVF_EN
    assign overflow = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module  : tb_alu_seq
// Purpose : Self-checking bench for alu_seq: directed vector table, hand
//           sequences for shift/reset corner cases, and random operations
//           checked against a behavioural model. Overflow checks are built
//           when ALU_OVF_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  alu_control;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        zero;
    logic        busy;
    logic        done;
`ifdef ALU_OVF_EN
    logic        overflow;
`endif

    int n_checks;
    int n_errors;
    logic [31:0] exp_prev;   // result the DUT should be holding between ops

    alu_seq #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .alu_control (alu_control),
        .a           (a),
        .b           (b),
        .shamt       (shamt),
        .result      (result),
        .zero        (zero),
        .busy        (busy),
        .done        (done)
`ifdef ALU_OVF_EN
        ,
        .overflow    (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] x,
                                              input logic [31:0] y, input logic [4:0] sh);
        case (op)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b0111: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b1111: return y << sh;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [4:0] sh);
        return (op == 4'b1111) ? 1 + int'(sh) : 1;
    endfunction

    function automatic logic model_ovf(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (op == 4'b0010) r = sx + sy;
        else if (op == 4'b0110) r = sx - sy;
        else return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    // ---------------- one transaction, fully checked ----------------
    task automatic check_op(input string name, input logic [3:0] op, input logic [31:0] ia,
                            input logic [31:0] ib, input logic [4:0] sh,
                            input logic [31:0] exp_res, input logic exp_zero,
                            input int exp_lat, input logic exp_ovf, input bit extra);
        int lat;
        int bcnt;
        bit held;
        logic [31:0] got_res;
        logic got_zero;
        logic got_ovf;
        lat = 0; bcnt = 0; held = 1'b1; got_res = 'x; got_zero = 1'bx; got_ovf = 1'b0;
        @(negedge clk);
        start = 1'b1; alu_control = op; a = ia; b = ib; shamt = sh;
        @(posedge clk); #1;                       // edge E passed, now cycle E+1
        start = 1'b0;
        alu_control = 4'($urandom); a = $urandom; b = $urandom; shamt = 5'($urandom);
        for (int c = 1; c <= 40; c++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = c; got_res = result; got_zero = zero;
`ifdef ALU_OVF_EN
                got_ovf = overflow;
`endif
                break;
            end
            if (result !== exp_prev) held = 1'b0;
            if (extra && (c % 3 == 0)) begin
                start = 1'b1; alu_control = 4'b0010;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({name, " latency"}, 64'(lat), 64'(exp_lat));
        chk({name, " result"}, 64'(got_res), 64'(exp_res));
        chk({name, " zero"}, 64'(got_zero), 64'(exp_zero));
        chk({name, " busy cycles"}, 64'(bcnt), 64'(exp_lat));
        chk({name, " result held"}, 64'(held), 64'd1);
`ifdef ALU_OVF_EN
        chk({name, " overflow"}, 64'(got_ovf), 64'(exp_ovf));
`else
        if (exp_ovf && got_ovf) $display("note: overflow not built");
`endif
        @(posedge clk); #1;
        chk({name, " idle after done"}, 64'({busy, done}), 64'd0);
        exp_prev = exp_res;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        zero;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    initial begin
        bit seen_done;
        n_checks = 0; n_errors = 0; exp_prev = 32'd0;

        vecs[0]  = '{4'b0010, 32'd5,          32'd7,          5'd0, 32'd12,         1'b0, 1};
        vecs[1]  = '{4'b0110, 32'd3,          32'd3,          5'd0, 32'd0,          1'b1, 1};
        vecs[2]  = '{4'b0111, 32'hFFFFFFFF,   32'd1,          5'd0, 32'd1,          1'b0, 1};
        vecs[3]  = '{4'b1111, 32'd0,          32'h1,          5'd4, 32'h10,         1'b0, 5};
        vecs[4]  = '{4'b1111, 32'd0,          32'hABCD,       5'd0, 32'hABCD,       1'b0, 1};
        vecs[5]  = '{4'b0000, 32'h0000F0F0,   32'h0000FF00,   5'd0, 32'h0000F000,   1'b0, 1};
        vecs[6]  = '{4'b0001, 32'd0,          32'd0,          5'd0, 32'd0,          1'b1, 1};
        vecs[7]  = '{4'b0011, 32'd5,          32'd9,          5'd3, 32'd0,          1'b1, 1};
        vecs[8]  = '{4'b0111, 32'd1,          32'hFFFFFFFF,   5'd0, 32'd0,          1'b1, 1};
        vecs[9]  = '{4'b0111, 32'h80000000,   32'h7FFFFFFF,   5'd0, 32'd1,          1'b0, 1};
        vecs[10] = '{4'b1111, 32'd0,          32'h80000001,   5'd1, 32'd2,          1'b0, 2};

        rst_n = 1'b0; start = 1'b0; alu_control = 4'd0; a = '0; b = '0; shamt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset result", 64'(result), 64'd0);
        chk("reset zero", 64'(zero), 64'd1);
        chk("reset busy/done", 64'({busy, done}), 64'd0);
`ifdef ALU_OVF_EN
        chk("reset overflow", 64'(overflow), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh,
                     vecs[i].res, vecs[i].zero, vecs[i].lat,
                     model_ovf(vecs[i].op, vecs[i].a, vecs[i].b), 1'b0);
        end

        // Extra start pulses during a long shift must be ignored
        check_op("sll31 with extra starts", 4'b1111, 32'd0, 32'h3, 5'd31,
                 32'h80000000, 1'b0, 32, 1'b0, 1'b1);

        // Reset in the middle of a shift aborts with no done
        @(negedge clk);
        start = 1'b1; alu_control = 4'b1111; b = 32'h5; shamt = 5'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midshift reset result", 64'(result), 64'd0);
        chk("midshift reset zero", 64'(zero), 64'd1);
        chk("midshift reset busy/done", 64'({busy, done}), 64'd0);
        seen_done = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (done) seen_done = 1'b1; end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin @(posedge clk); #1; if (done || busy) seen_done = 1'b1; end
        chk("no done after abort", 64'(seen_done), 64'd0);
        exp_prev = 32'd0;
        check_op("add after abort", 4'b0010, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0, 1, 1'b0, 1'b0);

`ifdef ALU_OVF_EN
        check_op("ovf add", 4'b0010, 32'h7FFFFFFF, 32'd1, 5'd0, 32'h80000000, 1'b0, 1, 1'b1, 1'b0);
        check_op("ovf sub", 4'b0110, 32'h80000000, 32'd1, 5'd0, 32'h7FFFFFFF, 1'b0, 1, 1'b1, 1'b0);
        check_op("ovf and", 4'b0000, 32'hFFFFFFFF, 32'h7FFFFFFF, 5'd0, 32'h7FFFFFFF, 1'b0, 1, 1'b0, 1'b0);
`endif

        // Random operations against the model
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [31:0] ra;
            logic [31:0] rb;
            logic [4:0]  rs;
            logic [31:0] er;
            case ($urandom_range(0, 6))
                0: op = 4'b0000;
                1: op = 4'b0001;
                2: op = 4'b0010;
                3: op = 4'b0110;
                4: op = 4'b0111;
                5: op = 4'b1111;
                default: op = 4'($urandom);
            endcase
            ra = $urandom; rb = $urandom; rs = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 4) == 0) rb = ra;
            er = model_res(op, ra, rb, rs);
            check_op($sformatf("rand%0d op%0h", i, op), op, ra, rb, rs, er, (er == 32'd0),
                     model_lat(op, rs), model_ovf(op, ra, rb), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
